// File: rtl/posit_encoder_pipe_pkg.sv
// Shared definitions for the posit packer: width helpers, the unpacked
// operand record and builders for the special posit bit patterns.
package posit_encoder_pipe_pkg;

    // Signed scale width for an n-bit posit with es exponent bits, plus margin bits.
    function automatic int GET_SCALE_WIDTH(input int n, input int es, input int margin);
        return es + $clog2(n) + 1 + margin;
    endfunction

    // Fraction width below the hidden bit, plus extra guard bits.
    function automatic int GET_FRACTION_WIDTH(input int n, input int es, input int guard_bits);
        return n - es - 3 + guard_bits;
    endfunction

    localparam int PKG_POSIT_WIDTH = 16;
    localparam int PKG_POSIT_ES    = 1;
    localparam int PKG_SCALE_WIDTH = GET_SCALE_WIDTH(PKG_POSIT_WIDTH, PKG_POSIT_ES, 1);
    localparam int PKG_FRAC_WIDTH  = GET_FRACTION_WIDTH(PKG_POSIT_WIDTH, PKG_POSIT_ES, 2);

    // Largest representable scale magnitude: (n-2) * 2^es.
    function automatic int get_max_scale(input int n, input int es);
        return (n - 2) << es;
    endfunction

    // NaR: sign bit set, everything else clear (slice to n bits at the use site).
    function automatic logic [63:0] nar_pattern(input int n);
        return 64'd1 << (n - 1);
    endfunction

    // maxpos body: n-1 ones.
    function automatic logic [63:0] maxpos_body(input int n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

    // minpos body: a single one in the LSB.
    function automatic logic [63:0] minpos_body();
        return 64'd1;
    endfunction

    // Unpacked operand as produced by the arithmetic datapath.
    typedef struct packed {
        logic                              sign;
        logic signed [PKG_SCALE_WIDTH-1:0] scale;
        logic [PKG_FRAC_WIDTH-1:0]         frac;
        logic                              sticky;
        logic                              zero;
        logic                              nar;
    } posit_unpacked_t;

endpackage

// File: rtl/posit_encoder_pipe_if.sv
// Valid/ready bundle for the posit packer: unpacked operand in, posit word out.
interface posit_encoder_pipe_if
    import posit_encoder_pipe_pkg::*;
#(
    parameter int POSIT_WIDTH   = PKG_POSIT_WIDTH,
    parameter int SCALE_WIDTH   = PKG_SCALE_WIDTH,
    parameter int FRAC_IN_WIDTH = PKG_FRAC_WIDTH
);
    logic                          in_valid;
    logic                          in_ready;
    logic                          in_sign;
    logic signed [SCALE_WIDTH-1:0] in_scale;
    logic [FRAC_IN_WIDTH-1:0]      in_frac;
    logic                          in_sticky;
    logic                          in_zero;
    logic                          in_nar;
    logic                          out_valid;
    logic                          out_ready;
    logic [POSIT_WIDTH-1:0]        out_posit;

    modport master (
        output in_valid, in_sign, in_scale, in_frac, in_sticky, in_zero, in_nar, out_ready,
        input  in_ready, out_valid, out_posit
    );

    modport slave (
        input  in_valid, in_sign, in_scale, in_frac, in_sticky, in_zero, in_nar, out_ready,
        output in_ready, out_valid, out_posit
    );
endinterface

// File: rtl/posit_encoder_pipe_round_rne.sv
// Body rounding for the posit packer. Macro POSIT_ENC_RNE_EN selects
// round-to-nearest-even; without it the guard/sticky bits are dropped
// (truncation). In both builds the result saturates at maxpos and never
// collapses to zero (minpos instead).
module posit_encoder_pipe_round_rne
    import posit_encoder_pipe_pkg::*;
#(
    parameter int POSIT_WIDTH = PKG_POSIT_WIDTH
) (
    input  logic [POSIT_WIDTH-2:0] body,
    input  logic                   g,
    input  logic                   s,
    output logic [POSIT_WIDTH-2:0] body_rounded
);
    localparam int BW = POSIT_WIDTH - 1;
    localparam logic [63:0]   MAXPOS_W = maxpos_body(POSIT_WIDTH);
    localparam logic [63:0]   MINPOS_W = minpos_body();
    localparam logic [BW-1:0] MAXPOS   = MAXPOS_W[BW-1:0];
    localparam logic [BW-1:0] MINPOS   = MINPOS_W[BW-1:0];

    logic          inc;
    logic [BW:0]   sum;

`ifdef POSIT_ENC_RNE_EN
    // Round up above half, or on an exact half when the body is odd.
    assign inc = g & (body[0] | s);
`else
    logic unused_round_bits;
    assign inc = 1'b0;
    assign unused_round_bits = g ^ s;
`endif

    // Apply the increment, then clamp into [minpos, maxpos].
    always_comb begin
        sum          = {1'b0, body} + {{BW{1'b0}}, inc};
        body_rounded = sum[BW-1:0];
        if (sum[BW]) begin
            body_rounded = MAXPOS;
        end else if (sum[BW-1:0] == '0) begin
            body_rounded = MINPOS;
        end
    end
endmodule

// File: rtl/posit_encoder_pipe.sv
// Three-stage posit packer: clamp/split scale, assemble regime|exp|frac
// into a body with guard and sticky, then round and apply sign/specials.
// Rounding mode is chosen by macro POSIT_ENC_RNE_EN (RNE when defined,
// truncation otherwise). Assumes POSIT_ES >= 1.
module posit_encoder_pipe
    import posit_encoder_pipe_pkg::*;
#(
    parameter int POSIT_WIDTH   = PKG_POSIT_WIDTH,
    parameter int POSIT_ES      = PKG_POSIT_ES,
    parameter int SCALE_WIDTH   = PKG_SCALE_WIDTH,
    parameter int FRAC_IN_WIDTH = PKG_FRAC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    posit_encoder_pipe_if.slave bus
);
    localparam int N     = POSIT_WIDTH;
    localparam int BW    = N - 1;
    localparam int MAXSH = N - 1;
    localparam int WF    = MAXSH + 1 + POSIT_ES + FRAC_IN_WIDTH;
    localparam int MAX_SCALE_I = get_max_scale(N, POSIT_ES);
    localparam logic signed [SCALE_WIDTH-1:0] MAX_SCALE_S = SCALE_WIDTH'(MAX_SCALE_I);
    localparam logic signed [SCALE_WIDTH-1:0] MIN_SCALE_S = SCALE_WIDTH'(-MAX_SCALE_I);
    localparam logic [63:0]  NAR_W    = nar_pattern(N);
    localparam logic [N-1:0] NAR_WORD = NAR_W[N-1:0];

    logic en;
    logic live_reg;

    // Stage 1 state
    logic                          s1_valid_reg;
    logic                          s1_sign_reg;
    logic signed [SCALE_WIDTH-1:0] s1_k_reg;
    logic [POSIT_ES-1:0]           s1_e_reg;
    logic [FRAC_IN_WIDTH-1:0]      s1_frac_reg;
    logic                          s1_sticky_reg;
    logic                          s1_zero_reg;
    logic                          s1_nar_reg;
    logic signed [SCALE_WIDTH-1:0] scale_clamped;
    logic [FRAC_IN_WIDTH-1:0]      frac_clamped;
    logic                          sticky_clamped;

    // Stage 2 state
    logic                   s2_valid_reg;
    logic                   s2_sign_reg;
    logic [BW-1:0]          s2_body_reg;
    logic                   s2_g_reg;
    logic                   s2_s_reg;
    logic                   s2_zero_reg;
    logic                   s2_nar_reg;
    logic [SCALE_WIDTH-1:0] sh;
    logic [31:0]            sh32;
    logic [WF-1:0]          init_top;
    logic [WF-1:0]          fill_mask;
    logic [WF-1:0]          field;

    // Stage 3 state
    logic [BW-1:0]  body_rounded;
    logic [N-1:0]   mag;
    logic [N-1:0]   posit_next;
    logic           out_valid_reg;
    logic [N-1:0]   out_posit_reg;

    // Whole pipe moves together; it only stalls when the output is held.
    assign en            = !out_valid_reg || bus.out_ready;
    assign bus.in_ready  = en && live_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_posit = out_posit_reg;

    // Keeps in_ready low until the first clock after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_reg <= 1'b0;
        end else begin
            live_reg <= 1'b1;
        end
    end

    // Clamp out-of-range scales to +/-maxscale with an exact (zero) fraction.
    always_comb begin
        scale_clamped  = bus.in_scale;
        frac_clamped   = bus.in_frac;
        sticky_clamped = bus.in_sticky;
        if (bus.in_scale > MAX_SCALE_S) begin
            scale_clamped  = MAX_SCALE_S;
            frac_clamped   = '0;
            sticky_clamped = 1'b0;
        end else if (bus.in_scale < MIN_SCALE_S) begin
            scale_clamped  = MIN_SCALE_S;
            frac_clamped   = '0;
            sticky_clamped = 1'b0;
        end
    end

    // Stage 1 register: split the clamped scale into regime k and exponent e.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s1_sign_reg   <= 1'b0;
            s1_k_reg      <= '0;
            s1_e_reg      <= '0;
            s1_frac_reg   <= '0;
            s1_sticky_reg <= 1'b0;
            s1_zero_reg   <= 1'b0;
            s1_nar_reg    <= 1'b0;
        end else if (en) begin
            s1_valid_reg  <= bus.in_valid && live_reg;
            s1_sign_reg   <= bus.in_sign;
            s1_k_reg      <= scale_clamped >>> POSIT_ES;
            s1_e_reg      <= scale_clamped[POSIT_ES-1:0];
            s1_frac_reg   <= frac_clamped;
            s1_sticky_reg <= sticky_clamped;
            s1_zero_reg   <= bus.in_zero;
            s1_nar_reg    <= bus.in_nar;
        end
    end

    // The regime run (all ones for k>=0, all zeros for k<0) fills the top sh bits.
    generate
        for (genvar gi = 0; gi < WF; gi++) begin : g_fill
            assign fill_mask[WF-1-gi] = !s1_k_reg[SCALE_WIDTH-1] && (sh32 > 32'(gi));
        end
    endgenerate

    // Place the regime terminator, e and frac under the run; the field is wide
    // enough that every shifted bit is still seen by the sticky OR.
    always_comb begin
        sh       = s1_k_reg[SCALE_WIDTH-1] ? -s1_k_reg : s1_k_reg + SCALE_WIDTH'(1);
        sh32     = 32'(sh);
        init_top = {s1_k_reg[SCALE_WIDTH-1], s1_e_reg, s1_frac_reg, {MAXSH{1'b0}}};
        field    = (init_top >> sh32) | fill_mask;
    end

    // Stage 2 register: n-1 body bits, guard, and sticky of everything below.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            s2_sign_reg  <= 1'b0;
            s2_body_reg  <= '0;
            s2_g_reg     <= 1'b0;
            s2_s_reg     <= 1'b0;
            s2_zero_reg  <= 1'b0;
            s2_nar_reg   <= 1'b0;
        end else if (en) begin
            s2_valid_reg <= s1_valid_reg;
            s2_sign_reg  <= s1_sign_reg;
            s2_body_reg  <= field[WF-1 -: BW];
            s2_g_reg     <= field[WF-1-BW];
            s2_s_reg     <= (|field[WF-2-BW:0]) | s1_sticky_reg;
            s2_zero_reg  <= s1_zero_reg;
            s2_nar_reg   <= s1_nar_reg;
        end
    end

    posit_encoder_pipe_round_rne #(
        .POSIT_WIDTH (N)
    ) u_round (
        .body         (s2_body_reg),
        .g            (s2_g_reg),
        .s            (s2_s_reg),
        .body_rounded (body_rounded)
    );

    // Apply sign by two's complement; zero and then NaR override (NaR wins).
    always_comb begin
        mag        = {1'b0, body_rounded};
        posit_next = s2_sign_reg ? -mag : mag;
        if (s2_zero_reg) begin
            posit_next = '0;
        end
        if (s2_nar_reg) begin
            posit_next = NAR_WORD;
        end
    end

    // Output register; holds while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_posit_reg <= '0;
        end else if (en) begin
            out_valid_reg <= s2_valid_reg;
            if (s2_valid_reg) begin
                out_posit_reg <= posit_next;
            end
        end
    end
endmodule

// File: doc/posit_encoder_pipe.md
Name: posit_encoder_pipe

Overview:
- Pipelined posit packer: takes an unpacked value (sign, signed scale, fraction, sticky, zero/NaR flags) and emits a rounded, saturated POSIT_WIDTH-bit posit word.
- Inverse of the posit field extractor; sits after the adder/multiplier/quire-normalize datapath and feeds the writeback stream.
- Valid/ready on both sides; one result per cycle at full throughput.

Parameters:
- POSIT_WIDTH, 16, posit word width n (n >= 8).
- POSIT_ES, 1, exponent field width es.
- SCALE_WIDTH, 7, signed two's-complement scale width; equals GET_SCALE_WIDTH(n, es, 1).
- FRAC_IN_WIDTH, 14, fraction bits below the hidden bit (hidden bit implicit, not supplied); must be >= n-es-3.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, upstream data valid.
- in_ready, output, 1, block accepts in_* this cycle.
- in_sign, input, 1, 1 = negative.
- in_scale, input, SCALE_WIDTH, signed power-of-two scale, value = 1.frac * 2^scale.
- in_frac, input, FRAC_IN_WIDTH, fraction MSB-first.
- in_sticky, input, 1, OR of discarded bits below in_frac.
- in_zero, input, 1, value is exactly zero.
- in_nar, input, 1, Not-a-Real; overrides in_zero.
- out_valid, output, 1, out_posit valid.
- out_ready, input, 1, downstream accepts.
- out_posit, output, POSIT_WIDTH, encoded posit.

Behaviour:
- Reset: out_valid=0, out_posit=0, all stage valids 0; in_ready=1 one cycle after release. Reset mid-operation discards in-flight data; no partial word emitted.
- Handshake: transfer on valid&&ready each side. Global advance en = !out_valid || out_ready; in_ready = en, combinational; a stage holds its data when !en. out_valid/out_posit stay stable while out_ready=0. Bubbles propagate; no combinational path in_valid -> out_valid.
- Latency: 3 cycles from input acceptance to out_valid with out_ready held high. Throughput 1/cycle. Order preserved.
- S1 (classify/clamp): maxscale = (n-2)*2^es. scale > maxscale -> clamp to maxscale with fraction forced 0, sticky 0; scale < -maxscale -> clamp to -maxscale likewise. Split k = scale >>> es (arithmetic), e = scale[es-1:0].
- S2 (assemble): regime = k>=0 ? (k+1) ones then a zero : (-k) zeros then a one. Concatenate regime | e | in_frac and shift right by regime length into a field wide enough to keep n-1 body bits, guard bit G, and sticky S = OR(remaining bits, in_sticky). Regime bits truncated by the field are never lost (clamp guarantees fit).
- S3 (round/pack): round-to-nearest-even on n-1 body bits: increment iff G && (L || S), L = body LSB. Body becomes all ones after increment -> hold at maxpos (0x7FFF for n=16). Nonzero value whose body is 0 -> minpos (body = 1). Never rounds to zero or NaR. Negative: out = two's complement of {0, body}. in_nar -> 1 followed by zeros (0x8000). in_zero -> all zeros. Register into out_posit.
- Simultaneous in_nar and in_zero: NaR wins.

Optional Feature:
- POSIT_ENC_RNE_EN defined: RNE rounding as above.
- Undefined: truncation (G, S ignored, no increment); minpos/maxpos clamping and NaR/zero handling unchanged; latency unchanged.

Decomposition:
- posit_defines package: add typedef struct for the unpacked input (sign, scale, frac, sticky, zero, nar) parameterised through localparams derived with GET_SCALE_WIDTH / GET_FRACTION_WIDTH; constants for maxscale, NaR pattern and maxpos/minpos body builders.
- One sub-module: posit_round_rne (combinational body+G+S -> rounded saturated body), instantiated in S3 and swapped for truncation under the macro.

Test Plan (n=16, es=1, FRAC_IN_WIDTH=14):
- sign0 scale0 frac0 -> 0x4000; sign1 same -> 0xC000; scale0 frac=0x2000 (1.5) -> 0x4800, each after exactly 3 cycles.
- scale28 -> 0x7FFF; scale40 -> 0x7FFF; scale -40 -> 0x0001; scale -40 sign1 -> 0xFFFF.
- RNE ties: scale0 frac=0x0006 -> 0x4002; frac=0x0002 sticky0 -> 0x4000; frac=0x0002 sticky1 -> 0x4001 (truncation build: 0x4001, 0x4000, 0x4000).
- in_nar=1 (with in_zero=1) -> 0x8000; in_zero=1 -> 0x0000.
- Back-to-back 8 inputs, out_ready low cycles 2-6 -> in_ready drops, out_posit stable while stalled, all 8 outputs in order, none duplicated or lost.
- Assert rst with 3 words in flight -> out_valid 0 immediately, no stale word after release; next input emerges 3 cycles after acceptance.
